mem_dist_pipe: RTL
==================

MEM_DIST_PIPE -- requirements
Module: mem_dist_pipe

Interface
REQ-001 WIDTH, 32, data word width in bits; SHALL be a multiple of BYTE_W.
REQ-002 DEPTH, 512, number of words; any value >= 2, power of two not required.
REQ-003 BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes.
REQ-004 RD_LAT, 1, read latency in cycles; legal range 1..3.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 init_busy  out  1  high while in reset or while the memory clear sweep runs.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_addr  in  $clog2(DEPTH)  write address.
REQ-010 wr_be  in  NB  per-lane write enable.
REQ-011 wr_data  in  WIDTH  write data.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_addr  in  $clog2(DEPTH)  read address.
REQ-014 rd_data  out  WIDTH  read data.
REQ-015 rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-016 par_err  out  1  parity mismatch on the returned word; qualified by rd_valid.

Function
REQ-017 Storage SHALL be distributed RAM (ram_style "distributed"), DEPTH x WIDTH, plus NB parity bits per word when parity is compiled in.
REQ-018 State machine SHALL be CLEAR -> READY; reset forces CLEAR with the sweep address set to 0.
REQ-019 CLEAR SHALL write all-zero data and matching parity to one address per cycle, 0 to DEPTH-1, then enter READY, taking exactly DEPTH cycles after rst_n rises.
REQ-020 init_busy SHALL be 1 in reset and in CLEAR, and 0 in READY.
REQ-021 While init_busy=1, wr_en and rd_en SHALL be ignored and no rd_valid SHALL issue.
REQ-022 In READY, wr_en=1 SHALL write lane i of wr_data when wr_be[i]=1; other lanes keep their contents. wr_be=0 is a no-op.
REQ-023 In READY, rd_en=1 SHALL produce rd_valid=1 with rd_data = mem[rd_addr] exactly RD_LAT cycles later. Back-to-back reads SHALL be accepted every cycle.
REQ-024 Same-cycle read and write to the same address SHALL return write-first data: enabled lanes from wr_data, other lanes from the old word.
REQ-025 rd_data SHALL hold its last value when rd_valid=0.
REQ-026 Address >= DEPTH: a write SHALL be discarded; a read SHALL return zero data, rd_valid=1 and par_err=0.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set rd_data=0, rd_valid=0, par_err=0 and init_busy=1, and SHALL flush all read-pipeline stages.
REQ-028 Reset asserted mid-CLEAR or mid-read SHALL abort the operation; the sweep restarts from address 0 after release.

Configuration
REQ-029 With MEM_DIST_PARITY_EN defined: one even-parity bit per lane SHALL be stored on write (per enabled lane) and on clear; on read, par_err = OR of the lane mismatches, aligned with rd_valid.
REQ-030 Without MEM_DIST_PARITY_EN: no parity storage or checking; par_err SHALL be tied to 0. The port list is identical in both builds.

Structure
REQ-031 Package mem_dist_pkg SHALL hold the FSM state enum (CLEAR, READY), the RD_LAT bounds, and a lane-parity function.
REQ-032 Sub-module mem_dist_array SHALL contain only the storage and its write port (per-lane enables, asynchronous read). mem_dist_pipe SHALL contain the FSM, bypass logic, pipeline and parity check.
REQ-033 An elaboration-time check SHALL reject WIDTH % BYTE_W != 0 and RD_LAT outside 1..3.

Verification
REQ-034 Release reset with DEPTH=512 -> init_busy falls exactly 512 cycles later; reading address 0 and address 511 returns 0 with par_err=0.
REQ-035 Write 0xDEADBEEF to address 5 with wr_be=4'b1111, then 0x000000AA with wr_be=4'b0001 -> read of address 5 returns 0xDEADBEAA after RD_LAT cycles.
REQ-036 Same cycle: write 0x11223344 with wr_be=4'b1100 and read, both at address 7 (old word 0) -> rd_data=0x11220000.
REQ-037 RD_LAT=3, reads of addresses 1, 2, 3 on consecutive cycles -> three consecutive rd_valid pulses, in order, starting 3 cycles after the first rd_en.
REQ-038 Pull rst_n low at sweep address 100, hold 2 cycles, release -> rd_valid=0 throughout, and init_busy stays high for a full DEPTH cycles after release.
REQ-039 MEM_DIST_PARITY_EN defined, force one stored parity bit of address 9 inverted, then read address 9 -> par_err=1 with rd_valid. Without the macro, the same stimulus gives par_err=0.

Source files
------------

// File: rtl/mem_dist_pkg.sv
// mem_dist shared types: clear/ready state, read-latency bounds, lane parity.
// No ports; imported by mem_dist_array and mem_dist_pipe.
package mem_dist_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Widest lane the parity helper accepts; narrower lanes are
    // zero-extended, which leaves even parity unchanged.
    localparam int PAR_W = 64;

    function automatic logic lane_par(input logic [PAR_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mem_dist_array.sv
// mem_dist storage: DEPTH x WIDTH distributed RAM, per-lane write, async read.
// Ports: clk, we/waddr/wdata (+wpar, rpar with MEM_DIST_PARITY_EN), raddr/rdata.
module mem_dist_array #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int BYTE_W = 8,
    parameter int NB     = WIDTH / BYTE_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [NB-1:0]    we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
`ifdef MEM_DIST_PARITY_EN
    input  logic [NB-1:0]    wpar,
    output logic [NB-1:0]    rpar,
`endif
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    (* ram_style = "distributed" *)
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign rdata = mem[raddr];

`ifdef MEM_DIST_PARITY_EN
    (* ram_style = "distributed" *)
    logic [NB-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we[i]) begin
                par_mem[waddr][i] <= wpar[i];
            end
        end
    end

    assign rpar = par_mem[raddr];
`endif

endmodule

// File: rtl/mem_dist_pipe.sv
// Distributed RAM with power-up clear sweep, write-first bypass, RD_LAT read pipe.
// Ports: clk, rst_n, init_busy, wr_en/wr_addr/wr_be/wr_data,
// rd_en/rd_addr, rd_data/rd_valid/par_err. Option: MEM_DIST_PARITY_EN.
module mem_dist_pipe
    import mem_dist_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 512,
    parameter int BYTE_W = 8,
    parameter int RD_LAT = 1,
    localparam int NB    = WIDTH / BYTE_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             init_busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [NB-1:0]    wr_be,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             par_err
);

    if ((WIDTH % BYTE_W) != 0 || RD_LAT < RD_LAT_MIN
        || RD_LAT > RD_LAT_MAX) begin : g_bad_cfg
        $error("mem_dist_pipe: illegal WIDTH/BYTE_W/RD_LAT");
    end

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t        state, state_nx;
    logic [AW-1:0] swp, swp_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= CLEAR;
            swp   <= '0;
        end else begin
            state <= state_nx;
            swp   <= swp_nx;
        end
    end

    always_comb begin
        state_nx = state;
        swp_nx   = swp;
        unique case (state)
            CLEAR: begin
                swp_nx = swp + AW'(1);
                if (swp == AW'(DEPTH - 1)) begin
                    state_nx = READY;
                    swp_nx   = '0;
                end
            end
            READY: ;
            default: state_nx = CLEAR;
        endcase
    end

    logic ready, clr, wr_ok, rd_ok, rd_in;

    assign ready     = rst_n && (state == READY);
    assign clr       = rst_n && (state == CLEAR);
    assign init_busy = !ready;
    assign wr_ok     = ready && wr_en && ({1'b0, wr_addr} < DEPTH_W);
    assign rd_ok     = ready && rd_en;
    assign rd_in     = {1'b0, rd_addr} < DEPTH_W;

    logic [NB-1:0]    a_we;
    logic [AW-1:0]    a_waddr;
    logic [WIDTH-1:0] a_wdata;
    logic [WIDTH-1:0] a_rdata;

    assign a_we    = clr ? '1 : (wr_ok ? wr_be : '0);
    assign a_waddr = clr ? swp : wr_addr;
    assign a_wdata = clr ? '0 : wr_data;

`ifdef MEM_DIST_PARITY_EN
    logic [NB-1:0] a_wpar, a_rpar;

    always_comb begin
        a_wpar = '0;
        for (int i = 0; i < NB; i++) begin
            a_wpar[i] = lane_par(PAR_W'(a_wdata[i*BYTE_W +: BYTE_W]));
        end
    end
`endif

    mem_dist_array #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .BYTE_W (BYTE_W),
        .NB     (NB),
        .AW     (AW)
    ) u_array (
        .clk    (clk),
        .we     (a_we),
        .waddr  (a_waddr),
        .wdata  (a_wdata),
`ifdef MEM_DIST_PARITY_EN
        .wpar   (a_wpar),
        .rpar   (a_rpar),
`endif
        .raddr  (rd_addr),
        .rdata  (a_rdata)
    );

    // Write-first: lanes being written this cycle come straight from
    // wr_data and carry freshly computed parity, so they never mismatch.
    logic [WIDTH-1:0] rd_word;
    logic [NB-1:0]    mis;

    always_comb begin
        rd_word = '0;
        mis     = '0;
        if (rd_in) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_ok && wr_addr == rd_addr && wr_be[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
                end else begin
                    rd_word[i*BYTE_W +: BYTE_W] = a_rdata[i*BYTE_W +: BYTE_W];
`ifdef MEM_DIST_PARITY_EN
                    mis[i] = lane_par(PAR_W'(a_rdata[i*BYTE_W +: BYTE_W]))
                             != a_rpar[i];
`endif
                end
            end
        end
    end

    // Stage data only moves with a valid token, so the last stage holds
    // the previous word while rd_valid is low.
    logic [RD_LAT-1:0] pv, pe;
    logic [WIDTH-1:0]  pd [RD_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            pe <= '0;
            for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
        end else begin
            pv[0] <= rd_ok;
            if (rd_ok) begin
                pd[0] <= rd_word;
                pe[0] <= |mis;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pv[i] <= pv[i-1];
                if (pv[i-1]) begin
                    pd[i] <= pd[i-1];
                    pe[i] <= pe[i-1];
                end
            end
        end
    end

    assign rd_valid = pv[RD_LAT-1];
    assign rd_data  = pd[RD_LAT-1];
    assign par_err  = pv[RD_LAT-1] & pe[RD_LAT-1];

endmodule
